uart_tx_frame_engine: RTL and testbench
=======================================

UART_TX_FRAME_ENGINE -- requirements
Module: uart_tx_frame_engine

Interface
REQ-001 The block SHALL have parameter data_width, default 8, giving payload bits per frame.
REQ-002 The block SHALL have parameter prescale_width, default 6, giving the width of the prescale input.
REQ-003 The block SHALL have parameter edge_counter_width, default 6, giving the width of the per-bit cycle counter, where edge_counter_width >= prescale_width.
REQ-004 Port tx_clk: input, 1 bit, sole clock; all state SHALL update on its rising edge.
REQ-005 Port rst: input, 1 bit, reset; it SHALL be asynchronous and active-high.
REQ-006 Port prescale: input, prescale_width bits, number of tx_clk cycles per serial bit.
REQ-007 Port par_en: input, 1 bit, inserts a parity bit when high.
REQ-008 Port par_typ: input, 1 bit, selects parity: 0 = even, 1 = odd.
REQ-009 Port p_data: input, data_width bits, payload word.
REQ-010 Port data_valid: input, 1 bit, requests transmission of p_data.
REQ-011 Port tx_out: output, 1 bit, serial line; idle level is 1.
REQ-012 Port busy: output, 1 bit, high while a frame is in progress.
REQ-013 Port frame_done: output, 1 bit, one-cycle pulse on the last cycle of the stop bit.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, START, DATA, PARITY and STOP.
REQ-015 A frame SHALL be sent in this order: start bit 0, then data_width data bits LSB first, then the parity bit only if par_en = 1, then one stop bit 1.
REQ-016 An acceptance SHALL occur when data_valid = 1 in IDLE, or in STOP on its final cycle.
REQ-017 At acceptance, the block SHALL latch p_data, par_en, par_typ and prescale, and SHALL move to START on the next edge.
REQ-018 Changes to these inputs after acceptance SHALL NOT affect the frame in flight.
REQ-019 data_valid SHALL be ignored at every time other than an acceptance point.
REQ-020 Each bit SHALL last exactly P tx_clk cycles, where P is the latched prescale.
- A latched prescale of 0 SHALL be treated as P = 1.
REQ-021 The edge counter SHALL count 0..P-1 within each bit.
- bit_done SHALL be true when the counter equals P-1.
- The counter SHALL clear to 0 on bit_done and whenever the FSM is in IDLE.
REQ-022 The bit counter SHALL count 0..data_width-1 in DATA, SHALL increment on each bit_done, and SHALL clear on leaving DATA.
- DATA SHALL exit on bit_done when the bit counter equals data_width-1.
REQ-023 State transitions on bit_done:
- START -> DATA.
- DATA (last bit) -> PARITY if par_en latched, else STOP.
- PARITY -> STOP.
- STOP -> START if data_valid = 1, else IDLE.
REQ-024 The parity bit SHALL be the XOR of the latched data for even parity, and the inverted XOR for odd parity.
REQ-025 tx_out SHALL be registered.
- It SHALL equal 1 in IDLE and STOP, 0 in START, the current data bit in DATA, and the parity value in PARITY.
- The first start-bit cycle SHALL appear on tx_out on the edge following acceptance (latency 1 cycle).
REQ-026 busy SHALL be registered and high in every state except IDLE.
- busy SHALL stay high across back-to-back frames.
REQ-027 frame_done SHALL be high for exactly the single cycle in which the FSM is in STOP with bit_done true, including when a back-to-back acceptance occurs in that cycle.
REQ-028 Frame length SHALL be (data_width + 2 + par_en) x P cycles.
REQ-029 A back-to-back stream SHALL have no idle cycle between the stop bit and the next start bit.

Reset
REQ-030 While rst = 1, the block SHALL hold: FSM = IDLE, tx_out = 1, busy = 0, frame_done = 0, edge counter = 0, bit counter = 0, and all latched data = 0.
REQ-031 Assertion of rst mid-frame SHALL immediately force the reset values listed in REQ-030.
- The interrupted frame SHALL be abandoned, not resumed.
REQ-032 After rst deasserts, the first acceptance SHALL be possible on the first rising edge at which the FSM is in IDLE.

Verification
REQ-033 Scenario: P = 4, par_en = 0, p_data = 8'hA5, one data_valid pulse -> tx_out = 0, 1,0,1,0,0,1,0,1, 1, each bit held 4 cycles; 40 cycles total; busy high 40 cycles; one frame_done pulse.
REQ-034 Scenario: P = 8, par_en = 1, par_typ = 0, p_data = 8'h07 -> parity bit = 1; with par_typ = 1 -> parity bit = 0; frame length = 88 cycles.
REQ-035 Scenario: data_valid held high for 3 frames of 8'h55 at P = 2 -> three contiguous 20-cycle frames, busy never low between them, 3 frame_done pulses.
REQ-036 Scenario: p_data and prescale changed mid-frame, data_valid pulsed mid-frame -> current frame unchanged; no extra frame is transmitted.
REQ-037 Scenario: rst asserted during the DATA state of a frame -> tx_out = 1 and busy = 0 immediately (asynchronously); a new frame after release transmits correctly.
REQ-038 Scenario: prescale = 0 and prescale = 63 with p_data = 8'hFF -> frames of 10 cycles and 630 cycles respectively, with correct bit boundaries.

Source files
------------

// File: rtl/uart_tx_frame_engine.sv
// UART transmit frame engine: start bit, LSB-first payload, optional parity, stop bit.
// Ports: tx_clk/rst (async high), prescale, par_en, par_typ, p_data, data_valid -> tx_out, busy, frame_done.
module uart_tx_frame_engine #(
  parameter int data_width         = 8,
  parameter int prescale_width     = 6,
  parameter int edge_counter_width = 6
) (
  input  logic                      tx_clk,
  input  logic                      rst,
  input  logic [prescale_width-1:0] prescale,
  input  logic                      par_en,
  input  logic                      par_typ,
  input  logic [data_width-1:0]     p_data,
  input  logic                      data_valid,
  output logic                      tx_out,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int EW = edge_counter_width;
  localparam int BW = (data_width > 1) ? $clog2(data_width) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [EW-1:0]             r_edge_cnt;
  logic [EW-1:0]             w_edge_nxt;
  logic [EW-1:0]             w_edge_last;
  logic [BW-1:0]             r_bit_cnt;
  logic [BW-1:0]             w_bit_nxt;
  logic [data_width-1:0]     r_data;
  logic [prescale_width-1:0] r_prescale;
  logic                      r_par_en;
  logic                      r_par_typ;
  logic                      r_tx;
  logic                      r_busy;
  logic                      w_bit_done;
  logic                      w_last_bit;
  logic                      w_accept;
  logic                      w_tx_nxt;

  // A latched prescale of zero behaves as one cycle per bit.
  assign w_edge_last = (r_prescale == '0) ? '0
                     : EW'(r_prescale) - EW'(1);
  assign w_bit_done  = (r_edge_cnt == w_edge_last);
  assign w_last_bit  = (r_bit_cnt == BW'(data_width - 1));

  // New words are taken only when idle or on the final stop cycle.
  assign w_accept = data_valid &&
                    ((r_state == IDLE) ||
                     ((r_state == STOP) && w_bit_done));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (data_valid) w_state_nxt = START;
      end
      START: begin
        if (w_bit_done) w_state_nxt = DATA;
      end
      DATA: begin
        if (w_bit_done && w_last_bit)
          w_state_nxt = r_par_en ? PARITY : STOP;
      end
      PARITY: begin
        if (w_bit_done) w_state_nxt = STOP;
      end
      STOP: begin
        if (w_bit_done)
          w_state_nxt = data_valid ? START : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_edge_nxt = r_edge_cnt + EW'(1);
    if ((r_state == IDLE) || w_bit_done)
      w_edge_nxt = '0;
  end

  always_comb begin
    w_bit_nxt = '0;
    if (r_state == DATA) begin
      if (!w_bit_done)
        w_bit_nxt = r_bit_cnt;
      else if (!w_last_bit)
        w_bit_nxt = r_bit_cnt + BW'(1);
    end
  end

  // tx_out is registered from next-state values so the line
  // level lines up with the state it belongs to.
  always_comb begin
    w_tx_nxt = 1'b1;
    unique case (w_state_nxt)
      IDLE:    w_tx_nxt = 1'b1;
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = r_data[w_bit_nxt];
      PARITY:  w_tx_nxt = (^r_data) ^ r_par_typ;
      STOP:    w_tx_nxt = 1'b1;
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_edge_cnt <= w_edge_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= (w_state_nxt != IDLE);
    end
  end

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      r_data     <= '0;
      r_prescale <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
    end else if (w_accept) begin
      r_data     <= p_data;
      r_prescale <= prescale;
      r_par_en   <= par_en;
      r_par_typ  <= par_typ;
    end
  end

  assign tx_out     = r_tx;
  assign busy       = r_busy;
  assign frame_done = (r_state == STOP) && w_bit_done;

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Self-checking bench for uart_tx_frame_engine.
// Expected line waveforms are built from the frame format and compared per cycle.
module tb_uart_tx_frame_engine;

  logic       tx_clk;
  logic       rst;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic [7:0] p_data;
  logic       data_valid;
  logic       tx_out;
  logic       busy;
  logic       frame_done;

  int n_checks;
  int n_fail;

  uart_tx_frame_engine #(
    .data_width(8),
    .prescale_width(6),
    .edge_counter_width(6)
  ) dut (
    .tx_clk(tx_clk),
    .rst(rst),
    .prescale(prescale),
    .par_en(par_en),
    .par_typ(par_typ),
    .p_data(p_data),
    .data_valid(data_valid),
    .tx_out(tx_out),
    .busy(busy),
    .frame_done(frame_done)
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  // Entry: posedge+1 of the first start-bit cycle. Exit: posedge+1
  // of the cycle right after the stop bit.
  task automatic check_frame(input logic [7:0] d, input int p,
                             input bit pe, input bit pt,
                             input string nm);
    logic bits[$];
    int   pp;
    int   n;
    logic exp_fd;
    pp = (p == 0) ? 1 : p;
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back((^d) ^ pt);
    bits.push_back(1'b1);
    n = bits.size() * pp;
    for (int k = 0; k < n; k++) begin
      exp_fd = (k == n - 1);
      n_checks++;
      if (tx_out !== bits[k / pp]) begin
        n_fail++;
        $display("FAIL %s tx_out cycle %0d: got %b want %b",
                 nm, k, tx_out, bits[k / pp]);
      end
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy cycle %0d: got %b want 1", nm, k, busy);
      end
      n_checks++;
      if (frame_done !== exp_fd) begin
        n_fail++;
        $display("FAIL %s frame_done cycle %0d: got %b want %b",
                 nm, k, frame_done, exp_fd);
      end
      @(posedge tx_clk); #1;
    end
  endtask

  task automatic check_idle(input int cycles, input string nm);
    for (int k = 0; k < cycles; k++) begin
      n_checks++;
      if (tx_out !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s idle cycle %0d: tx=%b busy=%b fd=%b want 1/0/0",
                 nm, k, tx_out, busy, frame_done);
      end
      @(posedge tx_clk); #1;
    end
  endtask

  // Entry at posedge+1 with the DUT idle; exit at posedge+1 of the
  // first start-bit cycle. Inputs are scrambled after acceptance.
  task automatic start_frame(input logic [7:0] d, input int p,
                             input bit pe, input bit pt, input bit hold);
    p_data     = d;
    prescale   = 6'(p);
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    @(posedge tx_clk); #1;
    if (!hold) begin
      data_valid = 1'b0;
      p_data     = 8'($urandom);
      prescale   = 6'($urandom);
      par_en     = 1'($urandom);
      par_typ    = 1'($urandom);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    data_valid = 1'b1;
    p_data     = 8'h3C;
    prescale   = 6'd3;
    par_en     = 1'b1;
    par_typ    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge tx_clk); #1;
      n_checks++;
      if (tx_out !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset hold %0d: tx=%b busy=%b fd=%b want 1/0/0",
                 k, tx_out, busy, frame_done);
      end
    end
    // Release with data_valid already high: first edge accepts.
    rst = 1'b0;
    @(posedge tx_clk); #1;
    data_valid = 1'b0;
    check_frame(8'h3C, 3, 1'b1, 1'b0, "first_after_reset");
    check_idle(3, "after_first");
  endtask

  task automatic test_basic();
    start_frame(8'hA5, 4, 1'b0, 1'b0, 1'b0);
    check_frame(8'hA5, 4, 1'b0, 1'b0, "basic_a5_p4");
    check_idle(3, "basic_idle");
  endtask

  task automatic test_parity();
    start_frame(8'h07, 8, 1'b1, 1'b0, 1'b0);
    check_frame(8'h07, 8, 1'b1, 1'b0, "parity_even");
    check_idle(2, "parity_even_idle");
    start_frame(8'h07, 8, 1'b1, 1'b1, 1'b0);
    check_frame(8'h07, 8, 1'b1, 1'b1, "parity_odd");
    check_idle(2, "parity_odd_idle");
  endtask

  task automatic test_random();
    logic [7:0] d;
    int         p;
    bit         pe;
    bit         pt;
    for (int i = 0; i < 10; i++) begin
      d  = 8'($urandom);
      p  = $urandom_range(0, 5);
      pe = 1'($urandom);
      pt = 1'($urandom);
      start_frame(d, p, pe, pt, 1'b0);
      check_frame(d, p, pe, pt, "random");
      check_idle(1, "random_idle");
    end
  endtask

  task automatic test_back_to_back();
    start_frame(8'h55, 2, 1'b0, 1'b0, 1'b1);
    fork
      begin
        check_frame(8'h55, 2, 1'b0, 1'b0, "b2b_1");
        check_frame(8'h55, 2, 1'b0, 1'b0, "b2b_2");
        check_frame(8'h55, 2, 1'b0, 1'b0, "b2b_3");
      end
      begin
        repeat (45) @(posedge tx_clk);
        #2 data_valid = 1'b0;
      end
    join
    check_idle(4, "b2b_idle");
  endtask

  task automatic test_mid_change();
    logic [7:0] d;
    d = 8'($urandom);
    start_frame(d, 4, 1'b1, 1'b1, 1'b0);
    fork
      check_frame(d, 4, 1'b1, 1'b1, "mid_change");
      begin
        repeat (5) @(posedge tx_clk);
        #2;
        data_valid = 1'b1;
        p_data     = ~d;
        prescale   = 6'd1;
        par_en     = 1'b0;
        @(posedge tx_clk);
        #2 data_valid = 1'b0;
      end
    join
    check_idle(12, "no_extra_frame");
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    start_frame(8'hF0, 4, 1'b1, 1'b0, 1'b0);
    repeat (14) @(posedge tx_clk);
    #3;
    n_checks++;
    if (tx_out !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset data bit: tx=%b busy=%b want 0/1",
               tx_out, busy);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: tx=%b busy=%b fd=%b want 1/0/0",
               tx_out, busy, frame_done);
    end
    repeat (2) @(posedge tx_clk);
    #1 rst = 1'b0;
    check_idle(3, "post_reset");
    d = 8'($urandom);
    start_frame(d, 3, 1'b1, 1'b1, 1'b0);
    check_frame(d, 3, 1'b1, 1'b1, "after_mid_reset");
    check_idle(2, "after_mid_reset_idle");
  endtask

  task automatic test_prescale_bounds();
    start_frame(8'hFF, 0, 1'b0, 1'b0, 1'b0);
    check_frame(8'hFF, 0, 1'b0, 1'b0, "prescale0");
    check_idle(2, "prescale0_idle");
    start_frame(8'hFF, 63, 1'b0, 1'b0, 1'b0);
    check_frame(8'hFF, 63, 1'b0, 1'b0, "prescale63");
    check_idle(2, "prescale63_idle");
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    data_valid = 1'b0;
    p_data     = '0;
    prescale   = '0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_parity();
    test_random();
    test_back_to_back();
    test_mid_change();
    test_reset_mid();
    test_prescale_bounds();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
